// File: rtl/pulp_cluster_package.sv
// Shared cluster types for core data ports and the peripheral arbiter depth.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pulp_cluster_package;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;

    // Outstanding-transaction depth the cluster uses for the peripheral arbiter.
    localparam int unsigned PeriphArbMaxOutstanding = 4;

    typedef struct packed {
        logic                 req;
        logic [AddrWidth-1:0] add;
        logic                 we;
        logic [DataWidth-1:0] data;
        logic [BeWidth-1:0]   be;
    } core_data_req_t;

    typedef struct packed {
        logic                 gnt;
        logic [DataWidth-1:0] r_data;
        logic                 r_valid;
    } core_data_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through and synchronous flush.
// Latency: 1 cycle push-to-pop (0 cycles when FALL_THROUGH and empty).
// Backpressure: pushes while full and pops while empty are ignored.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam logic [ADDR_DEPTH-1:0] LastPtr  = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   FullCnt  = (ADDR_DEPTH + 1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    dtype                  mem_d [DEPTH];
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);

    // Pointer/count update; a fall-through push+pop on empty bypasses storage.
    always_comb begin
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o   = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];
        if (FALL_THROUGH && empty_o && push_i && pop_i) begin
            push_ok = 1'b0;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/periph_req_arbiter.sv
// Round-robin arbiter of NumReq cores onto one in-order peripheral slave.
// Latency: request and grant pass combinationally; r_valid is routed in the same cycle.
// Backpressure: winner locked until slave gnt; new requests held off at MaxOutstanding.
module periph_req_arbiter
    import pulp_cluster_package::*;
#(
    parameter int unsigned NumReq         = 8,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  core_data_req_t req_i [NumReq],
    output core_data_rsp_t rsp_o [NumReq],
    output core_data_req_t slv_req_o,
    input  core_data_rsp_t slv_rsp_i,
    output logic           idle_o,
    output logic           err_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t LastIdx = IdxW'(NumReq - 1);

    idx_t rr_q, rr_d, lock_idx_q, lock_idx_d;
    logic lock_q, lock_d, err_q, err_d;
    idx_t rr_win, cand, win_idx, head_idx;
    logic any_req, pending, slv_req, hs;
    logic fifo_full, fifo_empty, fifo_pop, rst_ni;

    assign rst_ni = ~rst_i;

    // Round-robin search starting at rr_q; first asserted req wins.
    always_comb begin
        any_req = 1'b0;
        rr_win  = rr_q;
        cand    = rr_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!any_req && req_i[cand].req) begin
                any_req = 1'b1;
                rr_win  = cand;
            end
            cand = (cand == LastIdx) ? '0 : cand + 1'b1;
        end
    end

    // Slave request mux; the registered FIFO count gates req so r_valid never reaches it.
    always_comb begin
        win_idx       = lock_q ? lock_idx_q : rr_win;
        pending       = lock_q | any_req;
        slv_req       = pending & ~fifo_full & ~rst_i;
        hs            = slv_req & slv_rsp_i.gnt;
        fifo_pop      = slv_rsp_i.r_valid & ~fifo_empty & ~rst_i;
        slv_req_o     = req_i[win_idx];
        slv_req_o.req = slv_req;
    end

    // Per-core responses: grant to the winner only, r_valid to the FIFO head, r_data broadcast.
    always_comb begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            rsp_o[k]         = '0;
            rsp_o[k].r_data  = slv_rsp_i.r_data;
            rsp_o[k].gnt     = hs & (win_idx == idx_t'(k));
            rsp_o[k].r_valid = fifo_pop & (head_idx == idx_t'(k));
        end
    end

    // Next-state: advance pointer and release lock on handshake, lock while waiting for gnt.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (slv_rsp_i.r_valid & fifo_empty);
        if (hs) begin
            rr_d   = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            lock_d = 1'b0;
        end else if (slv_req) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    assign idle_o = ~lock_q & fifo_empty;
    assign err_o  = err_q;

    // Granted core IDs in grant order, so in-order responses find their owner.
    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxOutstanding)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (win_idx),
        .push_i  (hs),
        .data_o  (head_idx),
        .pop_i   (fifo_pop)
    );

endmodule

// File: tb/tb_periph_req_arbiter.sv
// Self-checking bench for periph_req_arbiter: directed scenarios plus a randomized model run.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Backpressure: slave gnt and r_valid driven directly by the bench.
module tb_periph_req_arbiter;
    import pulp_cluster_package::*;

    localparam int NumReq = 8;
    localparam int MaxOut = 4;

    logic           clk_i;
    logic           rst_i;
    core_data_req_t req_i [NumReq];
    core_data_rsp_t rsp_o [NumReq];
    core_data_req_t slv_req_o;
    core_data_rsp_t slv_rsp_i;
    logic           idle_o;
    logic           err_o;

    int n_checks = 0;
    int n_pass   = 0;

    periph_req_arbiter #(
        .NumReq         (NumReq),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .rsp_o     (rsp_o),
        .slv_req_o (slv_req_o),
        .slv_rsp_i (slv_rsp_i),
        .idle_o    (idle_o),
        .err_o     (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [NumReq-1:0] gnt_vec();
        logic [NumReq-1:0] v;
        for (int k = 0; k < NumReq; k++) v[k] = rsp_o[k].gnt;
        return v;
    endfunction

    function automatic logic [NumReq-1:0] rv_vec();
        logic [NumReq-1:0] v;
        for (int k = 0; k < NumReq; k++) v[k] = rsp_o[k].r_valid;
        return v;
    endfunction

    function automatic logic [NumReq-1:0] onehot(input int k);
        logic [NumReq-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NumReq; k++) req_i[k] = '0;
        slv_rsp_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int k = 0; k < NumReq; k++) begin
            req_i[k]      = '0;
            req_i[k].req  = 1'b1;
            req_i[k].add  = 32'h1000 + 32'(k);
        end
        slv_rsp_i         = '0;
        slv_rsp_i.gnt     = 1'b1;
        slv_rsp_i.r_valid = 1'b1;
        tick();
        settle();
        n_checks++;
        if (slv_req_o.req !== 1'b0) $display("FAIL reset_slv_req: got %0b want 0", slv_req_o.req);
        else n_pass++;
        n_checks++;
        if (gnt_vec() !== '0) $display("FAIL reset_gnt: got %b want 0", gnt_vec());
        else n_pass++;
        n_checks++;
        if (rv_vec() !== '0) $display("FAIL reset_rvalid: got %b want 0", rv_vec());
        else n_pass++;
        n_checks++;
        if (idle_o !== 1'b1) $display("FAIL reset_idle: got %0b want 1", idle_o);
        else n_pass++;
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_o);
        else n_pass++;
        tick();
        clear_inputs();
        rst_i = 1'b0;
        settle();
        n_checks++;
        if (dut.rr_q !== 3'd0) $display("FAIL reset_rr: got %0d want 0", dut.rr_q);
        else n_pass++;
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL post_reset_status: got idle=%0b err=%0b want idle=1 err=0", idle_o, err_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_alternate();
        int exp_w [4] = '{2, 5, 2, 5};
        apply_reset();
        req_i[2].req = 1'b1; req_i[2].add = 32'h200;
        req_i[5].req = 1'b1; req_i[5].add = 32'h500;
        slv_rsp_i.gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            slv_rsp_i.r_valid = (c > 0);
            settle();
            n_checks++;
            if (gnt_vec() !== onehot(exp_w[c]))
                $display("FAIL alt_grant[%0d]: got %b want %b", c, gnt_vec(), onehot(exp_w[c]));
            else n_pass++;
            n_checks++;
            if (rv_vec() !== ((c > 0) ? onehot(exp_w[(c > 0) ? c - 1 : 0]) : '0))
                $display("FAIL alt_rvalid[%0d]: got %b", c, rv_vec());
            else n_pass++;
            tick();
            if (c == 1) begin
                n_checks++;
                if (dut.rr_q !== 3'd6) $display("FAIL alt_rr_after_core5: got %0d want 6", dut.rr_q);
                else n_pass++;
            end
        end
        req_i[2].req = 1'b0;
        req_i[5].req = 1'b0;
        slv_rsp_i.gnt = 1'b0;
        slv_rsp_i.r_valid = 1'b1;
        settle();
        n_checks++;
        if (rv_vec() !== onehot(5)) $display("FAIL alt_drain_rvalid: got %b want %b", rv_vec(), onehot(5));
        else n_pass++;
        tick();
        slv_rsp_i.r_valid = 1'b0;
        settle();
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL alt_idle: got idle=%0b err=%0b want 1/0", idle_o, err_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_lock();
        apply_reset();
        req_i[3].add = 32'h3000; req_i[3].data = 32'h3333_3333; req_i[3].req = 1'b1;
        req_i[0].add = 32'h0100; req_i[0].data = 32'h0000_0011;
        for (int i = 1; i <= 4; i++) begin
            if (i >= 2) req_i[0].req = 1'b1;
            settle();
            n_checks++;
            if (slv_req_o.req !== 1'b1 || slv_req_o.add !== 32'h3000 || slv_req_o.data !== 32'h3333_3333)
                $display("FAIL lock_hold[%0d]: got req=%0b add=%h data=%h want 1/3000/33333333",
                         i, slv_req_o.req, slv_req_o.add, slv_req_o.data);
            else n_pass++;
            n_checks++;
            if (gnt_vec() !== '0) $display("FAIL lock_nogrant[%0d]: got %b want 0", i, gnt_vec());
            else n_pass++;
            tick();
        end
        slv_rsp_i.gnt = 1'b1;
        settle();
        n_checks++;
        if (gnt_vec() !== onehot(3) || slv_req_o.add !== 32'h3000)
            $display("FAIL lock_grant3: got gnt=%b add=%h want %b/3000", gnt_vec(), slv_req_o.add, onehot(3));
        else n_pass++;
        tick();
        req_i[3].req = 1'b0;
        settle();
        n_checks++;
        if (gnt_vec() !== onehot(0) || slv_req_o.add !== 32'h0100)
            $display("FAIL lock_grant0: got gnt=%b add=%h want %b/100", gnt_vec(), slv_req_o.add, onehot(0));
        else n_pass++;
        tick();
        req_i[0].req = 1'b0;
        slv_rsp_i.gnt = 1'b0;
        slv_rsp_i.r_valid = 1'b1;
        settle();
        n_checks++;
        if (rv_vec() !== onehot(3)) $display("FAIL lock_rsp3: got %b want %b", rv_vec(), onehot(3));
        else n_pass++;
        tick();
        settle();
        n_checks++;
        if (rv_vec() !== onehot(0)) $display("FAIL lock_rsp0: got %b want %b", rv_vec(), onehot(0));
        else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_full();
        apply_reset();
        req_i[1].req = 1'b1;
        slv_rsp_i.gnt = 1'b1;
        for (int c = 0; c < MaxOut; c++) begin
            settle();
            n_checks++;
            if (gnt_vec() !== onehot(1)) $display("FAIL full_fill[%0d]: got %b want %b", c, gnt_vec(), onehot(1));
            else n_pass++;
            tick();
        end
        slv_rsp_i.r_valid = 1'b1;
        settle();
        n_checks++;
        if (slv_req_o.req !== 1'b0 || gnt_vec() !== '0)
            $display("FAIL full_blocked: got req=%0b gnt=%b want 0/0", slv_req_o.req, gnt_vec());
        else n_pass++;
        n_checks++;
        if (rv_vec() !== onehot(1) || idle_o !== 1'b0)
            $display("FAIL full_pop: got rv=%b idle=%0b want %b/0", rv_vec(), idle_o, onehot(1));
        else n_pass++;
        tick();
        slv_rsp_i.r_valid = 1'b0;
        settle();
        n_checks++;
        if (slv_req_o.req !== 1'b1 || gnt_vec() !== onehot(1))
            $display("FAIL full_resume: got req=%0b gnt=%b want 1/%b", slv_req_o.req, gnt_vec(), onehot(1));
        else n_pass++;
        tick();
        req_i[1].req = 1'b0;
        slv_rsp_i.gnt = 1'b0;
        slv_rsp_i.r_valid = 1'b1;
        for (int c = 0; c < MaxOut; c++) begin
            settle();
            n_checks++;
            if (rv_vec() !== onehot(1)) $display("FAIL full_drain[%0d]: got %b want %b", c, rv_vec(), onehot(1));
            else n_pass++;
            tick();
        end
        slv_rsp_i.r_valid = 1'b0;
        settle();
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL full_idle: got idle=%0b err=%0b want 1/0", idle_o, err_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_in_order();
        int          order [3] = '{1, 7, 4};
        logic [31:0] rdat  [3] = '{32'hA, 32'hB, 32'hC};
        apply_reset();
        slv_rsp_i.gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NumReq; k++) req_i[k].req = (k == order[i]);
            settle();
            n_checks++;
            if (gnt_vec() !== onehot(order[i]))
                $display("FAIL order_grant[%0d]: got %b want %b", i, gnt_vec(), onehot(order[i]));
            else n_pass++;
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            slv_rsp_i.r_valid = 1'b1;
            slv_rsp_i.r_data  = rdat[i];
            settle();
            n_checks++;
            if (rv_vec() !== onehot(order[i]) || rsp_o[order[i]].r_data !== rdat[i])
                $display("FAIL order_rsp[%0d]: got rv=%b data=%h want %b/%h",
                         i, rv_vec(), rsp_o[order[i]].r_data, onehot(order[i]), rdat[i]);
            else n_pass++;
            n_checks++;
            if (rsp_o[(order[i] + 3) % NumReq].r_data !== rdat[i])
                $display("FAIL order_bcast[%0d]: got %h want %h", i, rsp_o[(order[i] + 3) % NumReq].r_data, rdat[i]);
            else n_pass++;
            tick();
        end
        clear_inputs();
        settle();
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL order_idle: got idle=%0b err=%0b want 1/0", idle_o, err_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_err();
        apply_reset();
        slv_rsp_i.r_valid = 1'b1;
        slv_rsp_i.r_data  = 32'h55;
        settle();
        n_checks++;
        if (rv_vec() !== '0 || err_o !== 1'b0)
            $display("FAIL err_spurious: got rv=%b err=%0b want 0/0", rv_vec(), err_o);
        else n_pass++;
        tick();
        slv_rsp_i.r_valid = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            settle();
            n_checks++;
            if (err_o !== 1'b1) $display("FAIL err_sticky[%0d]: got %0b want 1", c, err_o);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        slv_rsp_i.gnt = 1'b1;
        req_i[2].req = 1'b1;
        tick();
        req_i[2].req = 1'b0;
        req_i[3].req = 1'b1;
        tick();
        req_i[3].req = 1'b0;
        req_i[5].req = 1'b1;
        slv_rsp_i.gnt = 1'b0;
        tick();
        settle();
        n_checks++;
        if (idle_o !== 1'b0) $display("FAIL mid_busy: got idle=%0b want 0", idle_o);
        else n_pass++;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (slv_req_o.req !== 1'b0 || idle_o !== 1'b1 || dut.rr_q !== 3'd0)
            $display("FAIL mid_async: got req=%0b idle=%0b rr=%0d want 0/1/0", slv_req_o.req, idle_o, dut.rr_q);
        else n_pass++;
        tick();
        clear_inputs();
        rst_i = 1'b0;
        settle();
        n_checks++;
        if (idle_o !== 1'b1 || dut.rr_q !== 3'd0 || err_o !== 1'b0)
            $display("FAIL mid_after: got idle=%0b rr=%0d err=%0b want 1/0/0", idle_o, dut.rr_q, err_o);
        else n_pass++;
        tick();
        slv_rsp_i.r_valid = 1'b1;
        settle();
        n_checks++;
        if (rv_vec() !== '0) $display("FAIL mid_stale_rv: got %b want 0", rv_vec());
        else n_pass++;
        tick();
        slv_rsp_i.r_valid = 1'b0;
        settle();
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL mid_err: got %0b want 1", err_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int  m_rr;
        int  m_lock;
        int  m_q[$];
        bit  m_err;
        apply_reset();
        m_rr = 0; m_lock = -1; m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int                w;
            bit                exp_req, exp_idle, gnt_in, rv_in;
            logic [NumReq-1:0] exp_gnt, exp_rv;
            core_data_req_t    exp_s;
            for (int k = 0; k < NumReq; k++) begin
                if (k != m_lock) begin
                    req_i[k].req  = ($urandom_range(0, 2) == 0);
                    req_i[k].add  = $urandom;
                    req_i[k].data = $urandom;
                    req_i[k].we   = 1'($urandom);
                    req_i[k].be   = 4'($urandom);
                end
            end
            gnt_in = 1'($urandom_range(0, 1));
            rv_in  = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            slv_rsp_i.gnt     = gnt_in;
            slv_rsp_i.r_valid = rv_in;
            slv_rsp_i.r_data  = $urandom;
            w = m_lock;
            if (w < 0) begin
                for (int s = 0; s < NumReq; s++) begin
                    if (w < 0 && req_i[(m_rr + s) % NumReq].req) w = (m_rr + s) % NumReq;
                end
            end
            exp_req  = (w >= 0) && (m_q.size() < MaxOut);
            exp_gnt  = (exp_req && gnt_in) ? onehot(w) : '0;
            exp_rv   = (rv_in && m_q.size() > 0) ? onehot(m_q[0]) : '0;
            exp_idle = (m_lock < 0) && (m_q.size() == 0);
            settle();
            n_checks++;
            if (exp_req) begin
                exp_s = req_i[w];
                exp_s.req = 1'b1;
                if (slv_req_o !== exp_s)
                    $display("FAIL rnd_slv[%0d]: got req=%0b add=%h want req=1 add=%h (core %0d)",
                             cyc, slv_req_o.req, slv_req_o.add, exp_s.add, w);
                else n_pass++;
            end else begin
                if (slv_req_o.req !== 1'b0) $display("FAIL rnd_slv[%0d]: got req=%0b want 0", cyc, slv_req_o.req);
                else n_pass++;
            end
            n_checks++;
            if (gnt_vec() !== exp_gnt) $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, gnt_vec(), exp_gnt);
            else n_pass++;
            n_checks++;
            if (rv_vec() !== exp_rv) $display("FAIL rnd_rv[%0d]: got %b want %b", cyc, rv_vec(), exp_rv);
            else n_pass++;
            n_checks++;
            if (rsp_o[cyc % NumReq].r_data !== slv_rsp_i.r_data)
                $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, rsp_o[cyc % NumReq].r_data, slv_rsp_i.r_data);
            else n_pass++;
            n_checks++;
            if (idle_o !== exp_idle) $display("FAIL rnd_idle[%0d]: got %0b want %0b", cyc, idle_o, exp_idle);
            else n_pass++;
            n_checks++;
            if (err_o !== m_err) $display("FAIL rnd_err[%0d]: got %0b want %0b", cyc, err_o, m_err);
            else n_pass++;
            if (rv_in) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (exp_req && gnt_in) begin
                m_q.push_back(w);
                m_rr   = (w + 1) % NumReq;
                m_lock = -1;
            end else if (exp_req) begin
                m_lock = w;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_in_order();
        test_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
